// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - issue scoreboard and register-file writeback port scheduler
module issue_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int MAX_LAT  = 4,
  parameter int LAT_W    = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               issue_valid,
  input  logic [REG_AW-1:0]                  issue_rs,
  input  logic [REG_AW-1:0]                  issue_rt,
  input  logic                               issue_rs_used,
  input  logic                               issue_rt_used,
  input  logic [REG_AW-1:0]                  issue_rd,
  input  logic                               issue_rd_we,
  input  logic [LAT_W-1:0]                   issue_lat,
  input  logic                               flush,
  output logic                               issue_ready,
  output logic                               stall,
  output logic                               wb_valid,
  output logic [REG_AW-1:0]                  wb_rd,
  output logic                               busy,
  output logic [$clog2(MAX_LAT+1)-1:0]       inflight
);

  localparam int INF_W = $clog2(MAX_LAT+1);

  // Slot k holds the write that retires k cycles from now; slot 0 retires this cycle.
  logic [NUM_REGS-1:0] pending;
  logic [MAX_LAT-1:0]  slot_vld;
  logic [REG_AW-1:0]   slot_rd [MAX_LAT];

  logic [NUM_REGS-1:0] pending_nxt;
  logic [MAX_LAT-1:0]  slot_vld_nxt;
  logic [REG_AW-1:0]   slot_rd_nxt [MAX_LAT];

  logic [LAT_W-1:0]    eff_lat;
  logic                raw_hit;
  logic                waw_hit;
  logic                port_slot;
  logic                port_hit;
  logic                accept;
  logic                accept_wr;
  logic [INF_W-1:0]    count;

  // Effective latency: 0 behaves as 1, anything above MAX_LAT saturates.
  always_comb begin
    eff_lat = issue_lat;
    if (issue_lat == '0) begin
      eff_lat = LAT_W'(1);
    end else if (int'(issue_lat) > MAX_LAT) begin
      eff_lat = LAT_W'(MAX_LAT);
    end
  end

  // Hazard detection against current state; the write port is taken if the entry
  // now in slot L would shift into slot L-1, exactly where the new write must go.
  always_comb begin
    port_slot = 1'b0;
    for (int k = 0; k < MAX_LAT; k++) begin
      if (int'(eff_lat) == k) begin
        port_slot = slot_vld[k];
      end
    end
    raw_hit     = (issue_rs_used & pending[issue_rs]) | (issue_rt_used & pending[issue_rt]);
    waw_hit     = issue_rd_we & pending[issue_rd];
    port_hit    = issue_rd_we & port_slot;
    issue_ready = ~flush & ~(raw_hit | waw_hit | port_hit);
    stall       = issue_valid & ~issue_ready;
    accept      = issue_valid & issue_ready;
    accept_wr   = accept & issue_rd_we;
    wb_valid    = slot_vld[0] & ~flush;
    wb_rd       = slot_rd[0];
  end

  // Occupancy summary of the slot pipeline.
  always_comb begin
    count = '0;
    for (int k = 0; k < MAX_LAT; k++) begin
      count = count + INF_W'(slot_vld[k]);
    end
    inflight = count;
    busy     = |slot_vld;
  end

  // Next state: shift slots down, insert the accepted write, retire-clear then issue-set pending.
  always_comb begin
    for (int k = 0; k < MAX_LAT - 1; k++) begin
      slot_vld_nxt[k] = slot_vld[k+1];
      slot_rd_nxt[k]  = slot_rd[k+1];
    end
    slot_vld_nxt[MAX_LAT-1] = 1'b0;
    slot_rd_nxt[MAX_LAT-1]  = '0;
    pending_nxt = pending;
    if (slot_vld[0]) begin
      pending_nxt[slot_rd[0]] = 1'b0;
    end
    if (accept_wr) begin
      pending_nxt[issue_rd] = 1'b1;
      for (int k = 0; k < MAX_LAT; k++) begin
        if (int'(eff_lat) - 1 == k) begin
          slot_vld_nxt[k] = 1'b1;
          slot_rd_nxt[k]  = issue_rd;
        end
      end
    end
    if (flush) begin
      pending_nxt  = '0;
      slot_vld_nxt = '0;
      for (int k = 0; k < MAX_LAT; k++) begin
        slot_rd_nxt[k] = '0;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending  <= '0;
      slot_vld <= '0;
      for (int k = 0; k < MAX_LAT; k++) begin
        slot_rd[k] <= '0;
      end
    end else begin
      pending  <= pending_nxt;
      slot_vld <= slot_vld_nxt;
      for (int k = 0; k < MAX_LAT; k++) begin
        slot_rd[k] <= slot_rd_nxt[k];
      end
    end
  end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Issue scoreboard and writeback-port scheduler for the Tinker pipeline, placed between the decoder stage and the register file. Tracks every in-flight instruction with a pending register write. Holds the PC/decoder via `stall` on RAW hazards, WAW hazards, and collisions on the single register-file write port. Drives the write-port strobe (`wb_valid`/`wb_rd`) when each tracked write reaches its scheduled cycle.

## Interface
- `NUM_REGS`, 32, architectural registers tracked (one pending bit each)
- `REG_AW`, 5, register index width
- `MAX_LAT`, 4, maximum issue-to-writeback latency in cycles (≥2)
- `LAT_W`, 3, width of `issue_lat`
- `clk` in 1: single clock, all state updates on rising edge
- `rst_n` in 1: synchronous active-low reset
- `issue_valid` in 1: decoder presents an instruction
- `issue_rs`, `issue_rt` in REG_AW: source registers
- `issue_rs_used`, `issue_rt_used` in 1: source operand actually read
- `issue_rd` in REG_AW: destination register
- `issue_rd_we` in 1: instruction writes `issue_rd`
- `issue_lat` in LAT_W: cycles from issue to writeback; 0 is treated as 1, values >MAX_LAT saturate to MAX_LAT
- `flush` in 1: kill all in-flight tracked writes
- `issue_ready` out 1: instruction accepted this cycle (combinational)
- `stall` out 1: `issue_valid & ~issue_ready`; routed to the PC stall input
- `wb_valid` out 1: register-file write strobe this cycle
- `wb_rd` out REG_AW: register being written back
- `busy` out 1: any slot occupied
- `inflight` out $clog2(MAX_LAT+1): number of occupied slots

## Operation
- State: `pending[NUM_REGS-1:0]`; slot shift register `slot_vld[MAX_LAT-1:0]`, `slot_rd[k]`.
- Slot index = cycles remaining until writeback. Slot 0 is the entry writing back this cycle.
- Hazards, evaluated combinationally on current state (L = effective latency):
  - RAW: `issue_rs_used & pending[issue_rs]`, or the same condition for rt.
  - WAW: `issue_rd_we & pending[issue_rd]`.
  - Port conflict: `issue_rd_we & L<MAX_LAT & slot_vld[L]`.
- `issue_ready = ~flush & ~(RAW | WAW | port)`. It is independent of `issue_valid`.
- Accept = `issue_valid & issue_ready`.
- Every edge:
  - Slots shift down: slot[k] ← slot[k+1]; slot[MAX_LAT-1] ← empty.
  - Accepted write (`issue_rd_we`) is inserted into slot[L-1] of the next state, overriding the shift. Port check guarantees that slot is empty.
  - `pending[issue_rd]` is set.
- Retire: `wb_valid = slot_vld[0] & ~flush`, `wb_rd = slot_rd[0]`.
  - The retiring rd's pending bit clears at the end of the cycle.
  - Same-edge retire-clear and issue-set of the same register cannot coexist (WAW blocks it). Set takes priority regardless.
- Accepted instruction with `issue_rd_we=0` occupies nothing. It is gated only by RAW.
- No bypass: a dependent instruction sees `pending` high through the writeback cycle.
- `flush=1`:
  - Next state: all slots empty, all pending bits clear.
  - `issue_ready=0` and `wb_valid=0` in the flush cycle.
- `inflight` = popcount(`slot_vld`); `busy` = |`slot_vld`.

## Timing
- Reset (rst_n low at an edge): pending=0, slots empty. Afterwards `wb_valid=0`, `wb_rd=0`, `busy=0`, `inflight=0`.
  - `issue_ready=1` (if no flush) and `stall=0` while `issue_valid=0`.
- Reset mid-operation discards all in-flight entries; no writeback strobe is produced for them.
- Instruction accepted in cycle c with latency L:
  - `pending[rd]` is high in cycles c+1 … c+L.
  - `wb_valid` is high exactly in cycle c+L.
  - The earliest dependent issue is c+L+1.
- Write port: at most one `wb_valid` per cycle by construction.
- `stall` is combinational from issue inputs and state. There is no registered delay.

## Test plan
- Reset, then issue rd=5 lat=1 at cycle c. Present rs=5 (used) at c+1.
  - Expect: `stall=1` at c+1, `wb_valid=1`/`wb_rd=5` at c+1, accept at c+2.
- Issue rd=6 lat=3 at c, then rd=7 lat=1 at c+2.
  - Expect: port-conflict stall at c+2, accept at c+3.
  - `wb_rd=6` at c+3, `wb_rd=7` at c+4.
- Issue rd=8 lat=4 at c, then rd=8 lat=1 at c+1.
  - Expect: WAW stall during c+1 … c+4, accept at c+5, `wb_valid` at c+6.
- Issue four independent writes rd=1..4, all lat=4, in c … c+3.
  - Expect: all accepted, `inflight=4` at c+4, `wb_rd`=1,2,3,4 in c+4 … c+7, `busy=0` at c+8.
- Issue rd=9 lat=4, assert `flush` two cycles later.
  - Expect: `issue_ready=0` in the flush cycle.
  - Next cycle: `inflight=0` and `pending[9]=0`; no `wb_valid` for rd=9 ever.
  - Identical outcome when `rst_n` is driven low instead of `flush`.
- Issue with `issue_lat=0` and with `issue_lat=7` (MAX_LAT=4).
  - Expect: writeback at c+1 and c+4 respectively.
